// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle for the bit-serial adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder cell plus carry flop
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, res_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q;
    logic             hs, hc, s, c, load, last;
    // full adder as two half adders
    always_comb begin
        hs   = opa_q[0] ^ opb_q[0];
        hc   = opa_q[0] & opb_q[0];
        s    = hs ^ carry_q;
        c    = hc | (hs & carry_q);
        load = bus.start && (state_q != RUN);
        last = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (state_q == RUN) state_d = last ? DONE : RUN;
        else                state_d = load ? RUN : IDLE;
    end
    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = (state_q == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (load) begin
            opa_q   <= bus.a;
            opb_q   <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            opa_q   <= opa_q >> 1;
            opb_q   <= opb_q >> 1;
            res_q   <= {s, res_q[WIDTH-1:1]};
            carry_q <= c;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                sum_q  <= {s, res_q[WIDTH-1:1]};
                cout_q <= c;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed scoreboard bench for 8-bit and 4-bit adders
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_edge = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [8:0] prev8 = 'x;
    int   bcnt8 = 0;
    int   bcnt4 = 0;
    int   dones8 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_edge <= rst;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(4)) if4 ();
    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // 8-bit monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        logic [8:0] e;
        check("excl8", {31'd0, if8.busy & if8.done}, 32'd0);
        if (if8.done) begin
            dones8++;
            if (q8.size() == 0) check("unexpected_done8", 32'd1, 32'd0);
            else begin
                e = q8.pop_front();
                check("result8", {23'd0, if8.cout, if8.sum}, {23'd0, e});
            end
            check("busy_len8", bcnt8, 8);
            bcnt8 = 0;
        end else begin
            bcnt8 = if8.busy ? bcnt8 + 1 : 0;
            if (!rst_edge) check("hold8", {23'd0, if8.cout, if8.sum}, {23'd0, prev8});
        end
        prev8 = {if8.cout, if8.sum};
    end

    always @(negedge clk) begin
        logic [4:0] e;
        if (if4.busy) bcnt4++;
        if (if4.done) begin
            if (q4.size() == 0) check("unexpected_done4", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                check("result4", {27'd0, if4.cout, if4.sum}, {27'd0, e});
            end
            check("busy_len4", bcnt4, 4);
            bcnt4 = 0;
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin, input bit push);
        if8.a = a; if8.b = b; if8.cin = cin; if8.start = 1'b1;
        if (push) q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
        @(posedge clk); #1;
        if8.start = 1'b0;
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
    endtask

    task automatic wait_done8();
        bit got = 0;
        for (int i = 0; i < 30; i++) if (!got) begin @(negedge clk); got = if8.done; end
        check("timeout8", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_done4();
        bit got = 0;
        for (int i = 0; i < 20; i++) if (!got) begin @(negedge clk); got = if4.done; end
        check("timeout4", {31'd0, got}, 32'd1);
    endtask

    initial begin
        logic [8:0] v;
        int d0;
        if8.start = 0; if8.a = 0; if8.b = 0; if8.cin = 0;
        if4.start = 0; if4.a = 0; if4.b = 0; if4.cin = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, if8.busy}, 0);
        check("rst_done", {31'd0, if8.done}, 0);
        check("rst_sum", {24'd0, if8.sum}, 0);
        check("rst_cout", {31'd0, if8.cout}, 0);
        issue8(8'h5A, 8'h33, 1'b0, 1); wait_done8();
        @(posedge clk); #1;
        issue8(8'hFF, 8'h01, 1'b0, 1); wait_done8();
        @(posedge clk); #1;
        issue8(8'hFF, 8'hFF, 1'b1, 1); wait_done8();
        repeat (3) @(negedge clk);
        check("held_sum", {24'd0, if8.sum}, 32'hFF);
        check("held_cout", {31'd0, if8.cout}, 1);
        issue8(8'h10, 8'h20, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1 issue8(8'hAA, 8'h55, 1'b0, 0);
        wait_done8();
        issue8(8'h01, 8'h01, 1'b0, 1);
        @(negedge clk);
        check("b2b_busy", {31'd0, if8.busy}, 1);
        wait_done8();
        @(posedge clk); #1;
        issue8(8'h77, 8'h11, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, if8.busy}, 0);
        check("abort_sum", {24'd0, if8.sum}, 0);
        check("abort_cout", {31'd0, if8.cout}, 0);
        d0 = dones8;
        repeat (12) @(negedge clk);
        check("abort_no_done", dones8 - d0, 0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) begin @(posedge clk); #1; end
            issue8(8'($urandom), 8'($urandom), 1'($urandom), 1);
            wait_done8();
        end
        @(posedge clk); #1;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            if4.a = v[3:0]; if4.b = v[7:4]; if4.cin = v[8]; if4.start = 1'b1;
            q4.push_back({1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'd0, v[8]});
            @(posedge clk); #1 if4.start = 1'b0;
            wait_done4();
        end
        repeat (10) @(negedge clk);
        check("q8_empty", q8.size(), 0);
        check("q4_empty", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
